// File: rtl/spi_bus_arbiter.sv
// rtl/spi_bus_arbiter.sv - round-robin Wishbone arbiter sharing one SPI SRAM controller slave
module spi_bus_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int MAX_BURST   = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NUM_MASTERS-1:0]    m_cyc_i,
   input  logic [NUM_MASTERS-1:0]    m_stb_i,
   input  logic [NUM_MASTERS*24-1:0] m_adr_i,
   input  logic [NUM_MASTERS-1:0]    m_we_i,
   input  logic [NUM_MASTERS*8-1:0]  m_dat_i,
   output logic [NUM_MASTERS-1:0]    m_ack_o,
   output logic [NUM_MASTERS-1:0]    m_err_o,
   output logic [7:0]                m_dat_o,
   output logic                      s_cyc_o,
   output logic                      s_stb_o,
   output logic [23:0]               s_adr_o,
   output logic                      s_we_o,
   output logic [7:0]                s_dat_o,
   input  logic                      s_ack_i,
   input  logic                      s_err_i,
   input  logic [7:0]                s_dat_i,
   output logic [NUM_MASTERS-1:0]    grant_o
);
   localparam int IW = (NUM_MASTERS > 2) ? 2 : 1;
   localparam int CW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

   typedef enum logic {IDLE, OWNED} state_e;

   state_e                 state_q, state_d;
   logic [IW-1:0]          owner_q, owner_d;
   logic [IW-1:0]          last_q, last_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [IW-1:0]          pick_idx;
   logic                   pick_found;
   logic [NUM_MASTERS-1:0] owner_oh;
   logic                   others_wait;
   logic                   burst_done;
   logic                   cnt_sat;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         owner_q <= '0;
         last_q  <= IW'(NUM_MASTERS - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   // Round-robin search starting just after the previous owner.
   always_comb begin
      logic [IW-1:0] cand;
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         cand = IW'((int'(last_q) + k) % NUM_MASTERS);
         if (!pick_found && m_cyc_i[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   assign owner_oh    = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << owner_q;
   assign others_wait = |(m_cyc_i & ~owner_oh);
   assign burst_done  = (MAX_BURST != 0) && ((int'(cnt_q) + 1) >= MAX_BURST);
   assign cnt_sat     = (MAX_BURST == 0) || (int'(cnt_q) >= MAX_BURST);

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      grant_o = '0;
      m_ack_o = '0;
      m_err_o = '0;
      m_dat_o = s_dat_i;
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      s_adr_o = '0;
      s_we_o  = 1'b0;
      s_dat_o = '0;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d = OWNED;
               owner_d = pick_idx;
               cnt_d   = '0;
            end
         end
         OWNED: begin
            grant_o = owner_oh;
            s_cyc_o = m_cyc_i[owner_q];
            s_stb_o = m_stb_i[owner_q];
            s_we_o  = m_we_i[owner_q];
            s_adr_o = m_adr_i[int'(owner_q)*24 +: 24];
            s_dat_o = m_dat_i[int'(owner_q)*8 +: 8];
            m_ack_o = s_ack_i ? owner_oh : '0;
            m_err_o = s_err_i ? owner_oh : '0;
            // Every release goes through IDLE so the controller sees chip select drop.
            if (!m_cyc_i[owner_q]) begin
               state_d = IDLE;
               last_d  = owner_q;
            end else if (s_ack_i && burst_done && others_wait) begin
               state_d = IDLE;
               last_d  = owner_q;
            end else if ((s_ack_i || s_err_i) && !cnt_sat) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
      endcase
   end
endmodule
